// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stage logic (master) and pipe_ctrl (slave).
// Carries memory request/response strobes, hazard/flush requests and per-stage enables.
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 5
);
    logic                  imem_req;
    logic                  imem_resp;
    logic                  dmem_req;
    logic                  dmem_resp;
    logic                  hazard_stall;
    logic                  flush;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  flush_ack;
    logic                  imem_discard;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp, hazard_stall, flush,
        input  stage_en, stage_valid, flush_ack, imem_discard
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp, hazard_stall, flush,
        output stage_en, stage_valid, flush_ack, imem_discard
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: per-stage enables and valid bits, memory waits, load-use
// bubbles and flush squash. Define PIPE_CTRL_PERF_EN to add the perf_* stall/flush counters.
module pipe_ctrl #(
    parameter int NUM_STAGES      = 5,
    parameter int IMEM_RESP_STAGE = 1,
    parameter int DMEM_RESP_STAGE = 4,
    parameter int HAZ_STAGE       = 1,
    parameter int FLUSH_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_imem_stall,
    output logic [31:0] perf_dmem_stall,
    output logic [31:0] perf_haz_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam logic [NUM_STAGES-1:0] VALID_RST = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic                  imem_pend_q, imem_pend_d;
    logic                  imem_drop_q, imem_drop_d;
    logic                  dmem_pend_q, dmem_pend_d;

    logic [NUM_STAGES-1:0] wait_c, stall_c, en_c;
    logic                  fetch_busy, wait_imem, wait_dmem, wait_haz;
    logic                  imem_resp_ok, flush_ack_c, drop_now;

    // A response owed to a squashed fetch must not satisfy the decode-side wait.
    assign imem_resp_ok = bus.imem_resp & ~imem_drop_q;

    assign fetch_busy = imem_pend_q & ~bus.imem_resp;
    assign wait_imem  = valid_q[IMEM_RESP_STAGE] & imem_pend_q & ~imem_resp_ok;
    assign wait_dmem  = valid_q[DMEM_RESP_STAGE] & dmem_pend_q & ~bus.dmem_resp;
    assign wait_haz   = valid_q[HAZ_STAGE] & bus.hazard_stall;

    always_comb begin
        wait_c = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            wait_c[i] = ((i == 0) & fetch_busy)
                      | ((i == IMEM_RESP_STAGE) & wait_imem)
                      | ((i == DMEM_RESP_STAGE) & wait_dmem)
                      | ((i == HAZ_STAGE) & wait_haz);
        end
    end

    // Back pressure ripples upstream only through stages that hold a real instruction.
    always_comb begin
        logic s;
        logic down_valid;
        stall_c    = '0;
        s          = 1'b0;
        down_valid = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            s          = wait_c[i] | (s & down_valid);
            stall_c[i] = s;
            down_valid = valid_q[i];
        end
    end

    assign en_c        = ~stall_c;
    assign flush_ack_c = bus.flush & en_c[FLUSH_DEPTH+1];
    assign drop_now    = flush_ack_c & imem_pend_q;

    always_comb begin
        logic incoming;
        valid_d  = valid_q;
        incoming = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (en_c[i]) begin
                valid_d[i] = incoming;
            end
            incoming = valid_q[i] & en_c[i];
            if (flush_ack_c && (i >= 1) && (i <= FLUSH_DEPTH)) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    assign imem_pend_d = (bus.imem_req & en_c[0]) | (imem_pend_q & ~bus.imem_resp);
    assign imem_drop_d = ~bus.imem_resp & (imem_drop_q | drop_now);
    assign dmem_pend_d = (bus.dmem_req & en_c[DMEM_RESP_STAGE-1]) | (dmem_pend_q & ~bus.dmem_resp);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= VALID_RST;
            imem_pend_q <= 1'b0;
            imem_drop_q <= 1'b0;
            dmem_pend_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            imem_pend_q <= imem_pend_d;
            imem_drop_q <= imem_drop_d;
            dmem_pend_q <= dmem_pend_d;
        end
    end

    assign bus.stage_en     = en_c;
    assign bus.stage_valid  = valid_q;
    assign bus.flush_ack    = flush_ack_c;
    assign bus.imem_discard = bus.imem_resp & (imem_drop_q | drop_now);

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_imem_stall <= '0;
            perf_dmem_stall <= '0;
            perf_haz_stall  <= '0;
            perf_flush      <= '0;
        end else begin
            if (wait_imem)   perf_imem_stall <= perf_imem_stall + 32'd1;
            if (wait_dmem)   perf_dmem_stall <= perf_dmem_stall + 32'd1;
            if (wait_haz)    perf_haz_stall  <= perf_haz_stall + 32'd1;
            if (flush_ack_c) perf_flush      <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic, checked against an
// instruction-slot model with latency-driven memory responders.
module tb_pipe_ctrl;
    localparam int NS = 5;
    localparam int IS = 1;
    localparam int DS = 4;
    localparam int HS = 1;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.NUM_STAGES(NS)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_imem_stall, perf_dmem_stall, perf_haz_stall, perf_flush;
`endif

    pipe_ctrl #(
        .NUM_STAGES     (NS),
        .IMEM_RESP_STAGE(IS),
        .DMEM_RESP_STAGE(DS),
        .HAZ_STAGE      (HS),
        .FLUSH_DEPTH    (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_imem_stall(perf_imem_stall),
        .perf_dmem_stall(perf_dmem_stall),
        .perf_haz_stall (perf_haz_stall),
        .perf_flush     (perf_flush)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus
    bit s_ireq, s_dreq, s_haz, s_fl, force_resp;
    int ilat, dlat;
    bit i_resp, d_resp;

    // Reference model: slot[i] holds an instruction id, -1 for a bubble
    int slot [NS];
    int next_id;
    bit f_out, f_stale, d_out;
    int f_age, f_lat, d_age, d_lat;
    int unsigned c_imem, c_dmem, c_haz, c_flush;
    bit go [NS];
    logic [NS-1:0] e_en, e_valid;
    bit e_ack, e_disc, b_imem, b_dmem, b_haz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task model_reset();
        for (int i = 0; i < NS; i++) slot[i] = -1;
        slot[0] = next_id;
        next_id++;
        f_out   = 1'b0;
        f_stale = 1'b0;
        d_out   = 1'b0;
        f_age   = 0;
        d_age   = 0;
        f_lat   = 1;
        d_lat   = 1;
        c_imem  = 0;
        c_dmem  = 0;
        c_haz   = 0;
        c_flush = 0;
    endtask

    task sample();
        bit blk, room;
        i_resp = force_resp | (f_out && f_age >= f_lat);
        d_resp = force_resp | (d_out && d_age >= d_lat);
        bus.imem_req     = s_ireq;
        bus.imem_resp    = i_resp;
        bus.dmem_req     = s_dreq;
        bus.dmem_resp    = d_resp;
        bus.hazard_stall = s_haz;
        bus.flush        = s_fl;
        #4;
        b_imem = slot[IS] >= 0 && f_out && !(i_resp && !f_stale);
        b_dmem = slot[DS] >= 0 && d_out && !d_resp;
        b_haz  = slot[HS] >= 0 && s_haz;
        room = 1'b1;
        for (int i = NS - 1; i >= 0; i--) begin
            blk = (i == 0 && f_out && !i_resp) || (i == IS && b_imem) ||
                  (i == DS && b_dmem) || (i == HS && b_haz);
            go[i]      = !blk && room;
            room       = slot[i] < 0 || go[i];
            e_en[i]    = go[i];
            e_valid[i] = slot[i] >= 0;
        end
        e_ack  = s_fl && go[FD+1];
        e_disc = i_resp && (f_stale || (e_ack && f_out));
        if (!rst) begin
            check("stage_en", 32'(bus.stage_en), 32'(e_en));
            check("stage_valid", 32'(bus.stage_valid), 32'(e_valid));
            check("flush_ack", 32'(bus.flush_ack), 32'(e_ack));
            check("imem_discard", 32'(bus.imem_discard), 32'(e_disc));
`ifdef PIPE_CTRL_PERF_EN
            check("perf_imem_stall", perf_imem_stall, c_imem);
            check("perf_dmem_stall", perf_dmem_stall, c_dmem);
            check("perf_haz_stall", perf_haz_stall, c_haz);
            check("perf_flush", perf_flush, c_flush);
`endif
        end
    endtask

    task commit();
        if (b_imem) c_imem++;
        if (b_dmem) c_dmem++;
        if (b_haz)  c_haz++;
        if (e_ack)  c_flush++;
        for (int i = NS - 1; i >= 1; i--) begin
            if (go[i]) slot[i] = go[i-1] ? slot[i-1] : -1;
        end
        if (go[0]) begin
            slot[0] = next_id;
            next_id++;
        end
        if (e_ack) begin
            for (int i = 1; i <= FD; i++) slot[i] = -1;
        end
        if (i_resp) f_stale = 1'b0;
        else if (e_ack && f_out) f_stale = 1'b1;
        f_age++;
        d_age++;
        if (s_ireq && go[0]) begin
            f_out = 1'b1;
            f_age = 1;
            f_lat = ilat;
        end else if (i_resp) begin
            f_out = 1'b0;
        end
        if (s_dreq && go[DS-1]) begin
            d_out = 1'b1;
            d_age = 1;
            d_lat = dlat;
        end else if (d_resp) begin
            d_out = 1'b0;
        end
    endtask

    task tick();
        @(posedge clk);
        if (rst) model_reset();
        else commit();
        #1;
    endtask

    initial begin
        int cnt0, cnt1;
        rst        = 1'b1;
        s_ireq     = 1'b1;
        s_dreq     = 1'b1;
        s_haz      = 1'b0;
        s_fl       = 1'b0;
        force_resp = 1'b0;
        ilat       = 1;
        dlat       = 1;
        next_id    = 0;
        model_reset();
        sample(); tick();
        sample(); tick();
        rst = 1'b0;

        // Single-cycle memories: pipe fills one stage per cycle and never stalls
        for (int k = 0; k < 20; k++) begin
            sample();
            check("fill_en", 32'(bus.stage_en), 32'h1f);
            check("fill_valid", 32'(bus.stage_valid), (k < 5) ? ((32'd1 << (k + 1)) - 1) : 32'h1f);
            if (k == 0) begin
                check("rst_flush_ack", 32'(bus.flush_ack), 32'd0);
                check("rst_discard", 32'(bus.imem_discard), 32'd0);
            end
            tick();
        end

        // imem response three cycles late
        ilat = 4; sample(); tick(); ilat = 1;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (!bus.stage_en[0]) cnt0++;
            if (!bus.stage_en[1]) cnt1++;
            tick();
        end
        check("imem_stall_en0", cnt0, 3);
        check("imem_stall_en1", cnt1, 3);
        for (int k = 0; k < 8; k++) begin sample(); tick(); end
        sample(); check("refill_valid", 32'(bus.stage_valid), 32'h1f); tick();

        // dmem response two cycles late with a full pipe
        dlat = 3; sample(); tick(); dlat = 1;
        cnt0 = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (bus.stage_en == '0) cnt0++;
            check("dmem_valid_held", 32'(bus.stage_valid), 32'h1f);
            tick();
        end
        check("dmem_stall_cycles", cnt0, 2);

        // One-cycle load-use hazard
        s_haz = 1'b1;
        sample(); check("haz_en01", 32'(bus.stage_en[1:0]), 32'd0); tick();
        s_haz = 1'b0;
        cnt0 = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (!bus.stage_valid[2]) cnt0++;
            tick();
        end
        check("haz_bubbles", cnt0, 1);
`ifdef PIPE_CTRL_PERF_EN
        sample();
        check("perf_imem_total", perf_imem_stall, 32'd3);
        check("perf_dmem_total", perf_dmem_stall, 32'd2);
        check("perf_haz_total", perf_haz_stall, 32'd1);
        tick();
`endif

        // Flush with a fetch outstanding; its response lands two cycles later
        ilat = 3; sample(); tick(); ilat = 1;
        s_fl = 1'b1;
        sample(); check("flush_ack_now", 32'(bus.flush_ack), 32'd1); tick();
        s_fl = 1'b0;
        sample();
        check("flush_squash", 32'(bus.stage_valid[2:1]), 32'd0);
        check("flush_no_discard", 32'(bus.imem_discard), 32'd0);
        tick();
        sample();
        check("late_discard", 32'(bus.imem_discard), 32'd1);
        check("late_s1_invalid", 32'(bus.stage_valid[1]), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin sample(); tick(); end
`ifdef PIPE_CTRL_PERF_EN
        sample(); check("perf_flush_total", perf_flush, 32'd1); tick();
`endif

        // Reset in the middle of an imem stall; a stray response afterwards is ignored
        ilat = 5; sample(); tick(); ilat = 1;
        sample(); tick();
        sample(); check("mid_stall_en0", 32'(bus.stage_en[0]), 32'd0); tick();
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        force_resp = 1'b1;
        sample();
        check("post_rst_valid", 32'(bus.stage_valid), 32'd1);
        check("post_rst_en", 32'(bus.stage_en), 32'h1f);
        check("post_rst_discard", 32'(bus.imem_discard), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check("post_rst_perf", perf_imem_stall | perf_dmem_stall | perf_haz_stall | perf_flush,
              32'd0);
`endif
        tick();
        force_resp = 1'b0;

        // Random traffic; flush is held until acknowledged
        for (int k = 0; k < 400; k++) begin
            s_ireq = $urandom_range(0, 3) != 0;
            s_dreq = $urandom_range(0, 1) == 1;
            s_haz  = $urandom_range(0, 7) == 0;
            ilat   = int'($urandom_range(1, 3));
            dlat   = int'($urandom_range(1, 3));
            if (!s_fl) s_fl = $urandom_range(0, 9) == 0;
            sample();
            tick();
            if (e_ack) s_fl = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
